// File: rtl/score_bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : score_bcd_display                                             |
// | Purpose  : Sequential binary-to-BCD converter (shift-add-3, one input    |
// |            bit per clock) driving five active-low 7-segment digits.      |
// | Ports    : clk      - system clock, rising edge                          |
// |            resetn   - synchronous active-low reset                       |
// |            start    - convert request, honoured only when not shifting   |
// |            bin      - binary value, captured on the accepting edge       |
// |            busy     - high while the conversion is shifting              |
// |            done     - one-cycle pulse, bcd/hex* hold the new result      |
// |            bcd      - packed BCD result, digit 0 in [3:0]                |
// |            hex0..4  - segments {g,f,e,d,c,b,a}, active-low, hex0 = LSD   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module score_bcd_display #(
  parameter int IN_W     = 14,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int BW = 4 * DIGITS;
  // At least five digits are decoded so every hex port has a source; any
  // extra digits still take part in leading-zero detection.
  localparam int ND = (DIGITS > 5) ? DIGITS : 5;

  localparam logic [6:0] SEG_ZERO   = 7'b1000000;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] HEX_RST_HI = (BLANK_LZ != 0) ? SEG_OFF : SEG_ZERO;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [IN_W-1:0] shreg;
  logic [BW-1:0]   scratch;
  logic [CW-1:0]   bitcnt;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   scr_nxt;
  logic [4*ND-1:0] pad;
  logic            last;
  logic            any_nz;
  logic [6:0]      seg_nxt [ND];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction applied independently to each digit before the shift.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? (scratch[4*i +: 4] + 4'd3)
                                                         : scratch[4*i +: 4];
    end
  endgenerate

  // Scratch after the shift: corrected digits move up, next binary bit enters.
  assign scr_nxt = {adj[BW-2:0], shreg[IN_W-1]};
  assign last    = (bitcnt == CW'(IN_W - 1));

  generate
    if (ND == DIGITS) begin : g_pad_none
      assign pad = scr_nxt;
    end else begin : g_pad_zero
      assign pad = {{(4 * (ND - DIGITS)){1'b0}}, scr_nxt};
    end
  endgenerate

  // Decode with leading-zero blanking: walk from the top digit down, a digit
  // is blank while nothing at or above it is non-zero. Digit 0 always shows.
  always_comb begin
    any_nz = 1'b0;
    for (int i = 0; i < ND; i++) begin
      seg_nxt[i] = SEG_OFF;
    end
    for (int i = ND - 1; i >= 0; i--) begin
      any_nz = any_nz | (pad[4*i +: 4] != 4'd0);
      if ((BLANK_LZ != 0) && (i != 0) && !any_nz) begin
        seg_nxt[i] = SEG_OFF;
      end else begin
        seg_nxt[i] = seg7(pad[4*i +: 4]);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_SHIFT : S_IDLE;
      S_SHIFT: state_nxt = last  ? S_DONE  : S_SHIFT;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  // Datapath: capture, shift, and result load on the final shift edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shreg   <= '0;
      scratch <= '0;
      bitcnt  <= '0;
      bcd     <= '0;
      hex0    <= SEG_ZERO;
      hex1    <= HEX_RST_HI;
      hex2    <= HEX_RST_HI;
      hex3    <= HEX_RST_HI;
      hex4    <= HEX_RST_HI;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            bitcnt  <= '0;
          end
        end
        S_SHIFT: begin
          scratch <= scr_nxt;
          shreg   <= {shreg[IN_W-2:0], 1'b0};
          bitcnt  <= bitcnt + CW'(1);
          if (last) begin
            bcd  <= scr_nxt;
            hex0 <= seg_nxt[0];
            hex1 <= seg_nxt[1];
            hex2 <= seg_nxt[2];
            hex3 <= seg_nxt[3];
            hex4 <= seg_nxt[4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_score_bcd_display                                          |
// | Purpose  : Self-checking bench for score_bcd_display. Two instances      |
// |            (leading-zero blanking on and off) share stimulus and are     |
// |            compared every cycle against a decimal-arithmetic model.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_score_bcd_display;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [13:0] bin;

  logic        busy_b, done_b, busy_n, done_n;
  logic [19:0] bcd_b, bcd_n;
  logic [6:0]  hex0_b, hex1_b, hex2_b, hex3_b, hex4_b;
  logic [6:0]  hex0_n, hex1_n, hex2_n, hex3_n, hex4_n;

  always #5 clk = ~clk;

  score_bcd_display #(.IN_W(14), .DIGITS(5), .BLANK_LZ(1)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b),
    .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b), .hex3(hex3_b), .hex4(hex4_b)
  );

  score_bcd_display #(.IN_W(14), .DIGITS(5), .BLANK_LZ(0)) dut_n (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_n), .done(done_n), .bcd(bcd_n),
    .hex0(hex0_n), .hex1(hex1_n), .hex2(hex2_n), .hex3(hex3_n), .hex4(hex4_n)
  );

  int tests = 0;
  int fails = 0;
  bit chk   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  // Packed {hex4..hex0}; with blanking, digit i>=1 is dark when v < 10^i.
  function automatic logic [34:0] hexes(input int v, input bit blank);
    logic [34:0] r;
    for (int i = 0; i < 5; i++) begin
      if (blank && i >= 1 && v < pow10(i)) r[7*i +: 7] = 7'h7F;
      else                                 r[7*i +: 7] = seg_of((v / pow10(i)) % 10);
    end
    return r;
  endfunction

  int          m_left;   // shift cycles remaining; 0 = not converting
  bit          m_done;
  int          m_val;
  logic [19:0] m_bcd;
  logic [34:0] m_hexb, m_hexn;

  always @(posedge clk) begin
    if (!resetn) begin
      m_left = 0;
      m_done = 1'b0;
      m_bcd  = '0;
      m_hexb = {{4{7'h7F}}, 7'h40};
      m_hexn = {5{7'h40}};
    end else if (m_left == 0 && start) begin
      m_val  = int'(bin);
      m_left = 14;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_bcd  = to_bcd(m_val);
        m_hexb = hexes(m_val, 1'b1);
        m_hexn = hexes(m_val, 1'b0);
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (chk) begin
      check("busy_b", busy_b, (m_left > 0));
      check("done_b", done_b, m_done);
      check("bcd_b",  bcd_b,  m_bcd);
      check("hex_b",  {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b}, m_hexb);
      check("busy_n", busy_n, (m_left > 0));
      check("done_n", done_n, m_done);
      check("bcd_n",  bcd_n,  m_bcd);
      check("hex_n",  {hex4_n, hex3_n, hex2_n, hex1_n, hex0_n}, m_hexn);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [13:0] v);
    @(posedge clk); #1 start = 1'b1; bin = v;
    @(posedge clk); #1 start = 1'b0; bin = 14'($urandom);
  endtask

  // Counts negedges up to and including the done cycle; bounded.
  task automatic wait_done(output int n, output int busy_cnt, output bit ok);
    n = 0; busy_cnt = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done_b) begin
        ok = 1'b1;
        break;
      end
      if (busy_b) busy_cnt++;
    end
  endtask

  int          n, bc, dcount;
  bit          ok;
  logic [13:0] edge_vals [11] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

  initial begin
    resetn = 1'b0; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1; chk = 1'b1;

    @(negedge clk);
    check("rst_bcd",   bcd_b, 20'h0);
    check("rst_busy",  busy_b, 1'b0);
    check("rst_hex_b", {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b}, {{4{7'h7F}}, 7'h40});
    check("rst_hex_n", {hex4_n, hex3_n, hex2_n, hex1_n, hex0_n}, {5{7'h40}});

    // 12348: 14 busy cycles, done in the 15th cycle after the accept edge
    pulse_start(14'd12348);
    wait_done(n, bc, ok);
    check("t12348_ok",   ok, 1'b1);
    check("t12348_lat",  n, 15);
    check("t12348_busy", bc, 14);
    check("t12348_bcd",  bcd_b, 20'h12348);
    check("t12348_hex",  {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b},
          {7'h79, 7'h24, 7'h30, 7'h19, 7'h00});

    pulse_start(14'd0);
    wait_done(n, bc, ok);
    check("t0_ok",    ok, 1'b1);
    check("t0_bcd",   bcd_b, 20'h0);
    check("t0_hex_b", {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b}, {{4{7'h7F}}, 7'h40});
    check("t0_hex_n", {hex4_n, hex3_n, hex2_n, hex1_n, hex0_n}, {5{7'h40}});

    pulse_start(14'd16383);
    wait_done(n, bc, ok);
    check("tmax_bcd", bcd_b, 20'h16383);

    pulse_start(14'd10000);
    wait_done(n, bc, ok);
    check("t10k_bcd", bcd_b, 20'h10000);
    check("t10k_hex", {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b},
          {7'h79, 7'h40, 7'h40, 7'h40, 7'h40});

    // start mid-shift with bin=5 is ignored
    pulse_start(14'd16383);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; bin = 14'd5;
    @(posedge clk); #1 start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_b) dcount++;
    end
    check("mid_dones", dcount, 1);
    check("mid_bcd",   bcd_b, 20'h16383);

    // start held in the DONE cycle: back-to-back conversion
    pulse_start(14'd12348);
    wait_done(n, bc, ok);
    start = 1'b1; bin = 14'd42;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n, bc, ok);
    check("b2b_ok",  ok, 1'b1);
    check("b2b_lat", n, 15);
    check("b2b_bcd", bcd_b, 20'h00042);
    check("b2b_hex", {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b},
          {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});

    // reset on the 7th shift edge of a 9999 conversion
    pulse_start(14'd9999);
    repeat (6) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check("abort_busy", busy_b, 1'b0);
    check("abort_bcd",  bcd_b, 20'h0);
    check("abort_hex",  {hex4_b, hex3_b, hex2_b, hex1_b, hex0_b}, {{4{7'h7F}}, 7'h40});
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_b) dcount++;
    end
    check("abort_nodone", dcount, 0);

    // randomized traffic, model checks every cycle
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      start  = ($urandom_range(0, 3) == 0);
      resetn = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 3))
        0:       bin = 14'($urandom_range(0, 99));
        1:       bin = edge_vals[$urandom_range(0, 10)];
        default: bin = 14'($urandom_range(0, 16383));
      endcase
    end
    #1 resetn = 1'b1; start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
